// File: rtl/pl_bram_rd_engine.sv
// BRAM-to-AXI4-Stream read engine: streams len words starting at base_addr from a
// 1-cycle-latency BRAM through a 2-entry skid FIFO with a fall-through path.
module pl_bram_rd_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    busy_r;
  logic                    done_r;
  logic                    bram_en_r;
  logic [ADDR_WIDTH-1:0]   bram_addr_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [LEN_WIDTH-1:0]    rd_left_r;
  logic [LEN_WIDTH-1:0]    beat_cnt_r;
  logic                    rd_vld_r;
  logic [DATA_WIDTH-1:0]   fifo_mem_r [2];
  logic                    fifo_wr_ptr_r;
  logic                    fifo_rd_ptr_r;
  logic [1:0]              fifo_cnt_r;
  logic [1:0]              fifo_cnt_nxt_s;
  logic                    tvalid_s;
  logic                    hs_s;
  logic                    last_s;
  logic                    accept_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    credit_s;
  logic                    issue_s;
  logic                    finish_s;

  // The word on bram_dout is presented directly when the FIFO is empty, so a
  // read issued one cycle ago can be consumed without a buffer round trip.
  assign tvalid_s       = (fifo_cnt_r != 2'd0) | rd_vld_r;
  assign hs_s           = tvalid_s & m_axis_tready;
  assign last_s         = (beat_cnt_r == (len_r - LEN_ONE));
  assign accept_s       = start & (state_r == ST_IDLE) & ~busy_r;
  assign push_s         = rd_vld_r & ~((fifo_cnt_r == 2'd0) & hs_s);
  assign pop_s          = (fifo_cnt_r != 2'd0) & hs_s;
  assign fifo_cnt_nxt_s = fifo_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
  // Words still to land (read in the BRAM now) plus buffered words after this edge.
  assign credit_s       = (({1'b0, bram_en_r} + fifo_cnt_nxt_s) < 2'd2);
  assign issue_s        = (state_r == ST_RUN) & (rd_left_r != LEN_ZERO) & credit_s;
  assign finish_s       = (state_r == ST_DRAIN) & hs_s & last_s;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (len != LEN_ZERO)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Leave only once the final read is actually on the BRAM port.
        if (bram_en_r && (rd_left_r == LEN_ZERO)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (finish_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Command latch, read issue, beat counting and status pulses
  always_ff @(posedge aclk) begin
    if (areset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bram_en_r   <= 1'b0;
      bram_addr_r <= {ADDR_WIDTH{1'b0}};
      len_r       <= LEN_ZERO;
      rd_left_r   <= LEN_ZERO;
      beat_cnt_r  <= LEN_ZERO;
      rd_vld_r    <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      rd_vld_r <= bram_en_r;
      if (accept_s) begin
        len_r      <= len;
        beat_cnt_r <= LEN_ZERO;
        if (len != LEN_ZERO) begin
          busy_r      <= 1'b1;
          bram_en_r   <= 1'b1;
          bram_addr_r <= base_addr;
          rd_left_r   <= len - LEN_ONE;
        end else begin
          done_r    <= 1'b1;
          bram_en_r <= 1'b0;
        end
      end else begin
        bram_en_r <= issue_s;
        if (issue_s) begin
          bram_addr_r <= bram_addr_r + ADDR_STEP;
          rd_left_r   <= rd_left_r - LEN_ONE;
        end
        if (hs_s) begin
          beat_cnt_r <= beat_cnt_r + LEN_ONE;
        end
        if (done_r) begin
          busy_r <= 1'b0;
        end
        if (finish_s) begin
          done_r <= 1'b1;
        end
      end
    end
  end

  // Two-entry skid FIFO catching words the sink does not take immediately
  always_ff @(posedge aclk) begin
    if (areset) begin
      fifo_mem_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_mem_r[1] <= {DATA_WIDTH{1'b0}};
      fifo_wr_ptr_r <= 1'b0;
      fifo_rd_ptr_r <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wr_ptr_r] <= bram_dout;
        fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
      end
      if (pop_s) begin
        fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
      end
      fifo_cnt_r <= fifo_cnt_nxt_s;
    end
  end

  // Stream output selection: buffered head first, else the fresh BRAM word
  always_comb begin
    m_axis_tdata = {DATA_WIDTH{1'b0}};
    if (fifo_cnt_r != 2'd0) begin
      m_axis_tdata = fifo_mem_r[fifo_rd_ptr_r];
    end else if (rd_vld_r) begin
      m_axis_tdata = bram_dout;
    end else begin
      m_axis_tdata = {DATA_WIDTH{1'b0}};
    end
  end

  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tlast  = tvalid_s & last_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign bram_en       = bram_en_r;
  assign bram_addr     = bram_addr_r;

endmodule
